// File: rtl/adc_multi_demux_align.sv
// Multi-ADC sample demultiplexer/aligner: packs DEMUX words per ADC on the ADC0 sync edge.
// Optional per-ADC out-of-range counters are built when ADC_OVR_COUNT_EN is defined.
module adc_multi_demux_align #(
    parameter int NUM_ADCS    = 2,
    parameter int LANES       = 4,
    parameter int SAMPLE_BITS = 8,
    parameter int DEMUX       = 2
) (
    input  logic                                      adc_clk,
    input  logic                                      ctrl_reset,
    input  logic [NUM_ADCS*LANES*SAMPLE_BITS-1:0]       adc_data_in,
    input  logic [NUM_ADCS-1:0]                       adc_sync_in,
    input  logic [NUM_ADCS-1:0]                       adc_outofrange_in,
    input  logic [NUM_ADCS-1:0]                       adc_dcm_locked,
    input  logic                                      clear_flags,
    output logic [NUM_ADCS*DEMUX*LANES*SAMPLE_BITS-1:0] user_data_out,
    output logic [NUM_ADCS*DEMUX-1:0]                 user_sync_out,
    output logic [NUM_ADCS*DEMUX-1:0]                 user_outofrange,
    output logic                                      user_data_valid,
    output logic                                      aligned,
    output logic                                      sync_err,
    output logic [NUM_ADCS-1:0]                       skew_err,
    output logic [NUM_ADCS*16-1:0]                    ovr_count
);

    localparam int AW = LANES * SAMPLE_BITS;
    localparam int W  = NUM_ADCS * AW;
    localparam int OW = DEMUX * W;
    localparam int SL = NUM_ADCS * DEMUX;
    localparam int PW = (DEMUX > 1) ? $clog2(DEMUX) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEMUX - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        RUN
    } state_t;

    logic [W-1:0]        in_data_q;
    logic [NUM_ADCS-1:0] in_sync_q;
    logic [NUM_ADCS-1:0] in_sync_prev_q;
    logic [NUM_ADCS-1:0] in_ovr_q;
    logic [NUM_ADCS-1:0] in_lock_q;
    logic                in_clear_q;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;

    logic [W-1:0]        slot_data_q [DEMUX];
    logic [W-1:0]        slot_data_d [DEMUX];
    logic [NUM_ADCS-1:0] slot_sync_q [DEMUX];
    logic [NUM_ADCS-1:0] slot_sync_d [DEMUX];
    logic [NUM_ADCS-1:0] slot_ovr_q  [DEMUX];
    logic [NUM_ADCS-1:0] slot_ovr_d  [DEMUX];

    logic [OW-1:0]       out_data_q, out_data_d;
    logic [SL-1:0]       out_sync_q, out_sync_d;
    logic [SL-1:0]       out_ovr_q, out_ovr_d;
    logic                valid_q, valid_d;
    logic                sync_err_q, sync_err_d;
    logic [NUM_ADCS-1:0] skew_err_q, skew_err_d;

    logic [NUM_ADCS-1:0] sync_edge;
    logic                all_locked;
    logic                store;
    logic [PW-1:0]       wr_idx;

    assign sync_edge  = in_sync_q & ~in_sync_prev_q;
    assign all_locked = &in_lock_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        slot_data_d = slot_data_q;
        slot_sync_d = slot_sync_q;
        slot_ovr_d  = slot_ovr_q;
        out_data_d  = out_data_q;
        out_sync_d  = out_sync_q;
        out_ovr_d   = out_ovr_q;
        valid_d     = 1'b0;
        sync_err_d  = sync_err_q;
        skew_err_d  = skew_err_q;
        store       = 1'b0;
        wr_idx      = '0;

        unique case (state_q)
            IDLE: begin
                if (all_locked) state_d = WAIT_SYNC;
            end
            WAIT_SYNC: begin
                if (!all_locked) begin
                    state_d = IDLE;
                end else if (sync_edge[0]) begin
                    state_d = RUN;
                    store   = 1'b1;
                end
            end
            RUN: begin
                if (!all_locked) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else begin
                    store = 1'b1;
                    // Off-phase ADC0 edge restarts the group at slot 0
                    if (sync_edge[0] && phase_q != '0) sync_err_d = 1'b1;
                    else wr_idx = phase_q;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase

        if (state_q == WAIT_SYNC || state_q == RUN) begin
            for (int k = 1; k < NUM_ADCS; k++) begin
                if (sync_edge[k] != sync_edge[0]) skew_err_d[k] = 1'b1;
            end
        end

        if (store) begin
            slot_data_d[wr_idx] = in_data_q;
            slot_sync_d[wr_idx] = in_sync_q;
            slot_ovr_d[wr_idx]  = in_ovr_q;
            if (wr_idx == LAST) begin
                phase_d = '0;
                valid_d = 1'b1;
                // Last slot comes straight from the input register
                for (int k = 0; k < NUM_ADCS; k++) begin
                    for (int j = 0; j < DEMUX; j++) begin
                        if (j == DEMUX - 1) begin
                            out_data_d[(k*DEMUX+j)*AW +: AW] = in_data_q[k*AW +: AW];
                            out_sync_d[k*DEMUX+j] = in_sync_q[k];
                            out_ovr_d[k*DEMUX+j]  = in_ovr_q[k];
                        end else begin
                            out_data_d[(k*DEMUX+j)*AW +: AW] = slot_data_q[j][k*AW +: AW];
                            out_sync_d[k*DEMUX+j] = slot_sync_q[j][k];
                            out_ovr_d[k*DEMUX+j]  = slot_ovr_q[j][k];
                        end
                    end
                end
            end else begin
                phase_d = wr_idx + 1'b1;
            end
        end

        if (in_clear_q) begin
            sync_err_d = 1'b0;
            skew_err_d = '0;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (ctrl_reset) begin
            in_data_q      <= '0;
            in_sync_q      <= '0;
            in_sync_prev_q <= '0;
            in_ovr_q       <= '0;
            in_lock_q      <= '0;
            in_clear_q     <= 1'b0;
            state_q        <= IDLE;
            phase_q        <= '0;
            out_data_q     <= '0;
            out_sync_q     <= '0;
            out_ovr_q      <= '0;
            valid_q        <= 1'b0;
            sync_err_q     <= 1'b0;
            skew_err_q     <= '0;
        end else begin
            in_data_q      <= adc_data_in;
            in_sync_q      <= adc_sync_in;
            in_sync_prev_q <= in_sync_q;
            in_ovr_q       <= adc_outofrange_in;
            in_lock_q      <= adc_dcm_locked;
            in_clear_q     <= clear_flags;
            state_q        <= state_d;
            phase_q        <= phase_d;
            out_data_q     <= out_data_d;
            out_sync_q     <= out_sync_d;
            out_ovr_q      <= out_ovr_d;
            valid_q        <= valid_d;
            sync_err_q     <= sync_err_d;
            skew_err_q     <= skew_err_d;
        end
    end

    // Slot contents are only read once a full group is assembled
    always_ff @(posedge adc_clk) begin
        slot_data_q <= slot_data_d;
        slot_sync_q <= slot_sync_d;
        slot_ovr_q  <= slot_ovr_d;
    end

`ifdef ADC_OVR_COUNT_EN
    logic [NUM_ADCS*16-1:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        for (int k = 0; k < NUM_ADCS; k++) begin
            if (state_q == RUN && in_ovr_q[k] && ovr_cnt_q[k*16 +: 16] != 16'hFFFF) begin
                ovr_cnt_d[k*16 +: 16] = ovr_cnt_q[k*16 +: 16] + 16'd1;
            end
        end
        if (in_clear_q) ovr_cnt_d = '0;
    end

    always_ff @(posedge adc_clk) begin
        if (ctrl_reset) ovr_cnt_q <= '0;
        else ovr_cnt_q <= ovr_cnt_d;
    end

    assign ovr_count = ovr_cnt_q;
`else
    assign ovr_count = '0;
`endif

    assign user_data_out   = out_data_q;
    assign user_sync_out   = out_sync_q;
    assign user_outofrange = out_ovr_q;
    assign user_data_valid = valid_q;
    assign aligned         = (state_q == RUN);
    assign sync_err        = sync_err_q;
    assign skew_err        = skew_err_q;

endmodule

// File: tb/tb_adc_multi_demux_align.sv
// Directed bench for adc_multi_demux_align: a DEMUX=2 and a DEMUX=4 instance share one stimulus.
// Counter expectations follow ADC_OVR_COUNT_EN.
module tb_adc_multi_demux_align;

    logic        clk = 1'b0;
    logic        ctrl_reset;
    logic [63:0] adc_data_in;
    logic [1:0]  adc_sync_in;
    logic [1:0]  adc_outofrange_in;
    logic [1:0]  adc_dcm_locked;
    logic        clear_flags;

    logic [127:0] d2_data;
    logic [3:0]   d2_sync;
    logic [3:0]   d2_ovr;
    logic         d2_valid;
    logic         d2_aligned;
    logic         d2_sync_err;
    logic [1:0]   d2_skew;
    logic [31:0]  d2_cnt;

    logic [255:0] d4_data;
    logic [7:0]   d4_sync;
    logic [7:0]   d4_ovr;
    logic         d4_valid;
    logic         d4_aligned;
    logic         d4_sync_err;
    logic [1:0]   d4_skew;
    logic [31:0]  d4_cnt;

    int errors = 0;
    int checks = 0;

`ifdef ADC_OVR_COUNT_EN
    localparam logic [31:0] OVR_EXP = 32'h0000_FFFF;
`else
    localparam logic [31:0] OVR_EXP = 32'h0;
`endif

    always #5 clk = ~clk;

    adc_multi_demux_align #(
        .NUM_ADCS(2), .LANES(4), .SAMPLE_BITS(8), .DEMUX(2)
    ) u2 (
        .adc_clk(clk),
        .ctrl_reset(ctrl_reset),
        .adc_data_in(adc_data_in),
        .adc_sync_in(adc_sync_in),
        .adc_outofrange_in(adc_outofrange_in),
        .adc_dcm_locked(adc_dcm_locked),
        .clear_flags(clear_flags),
        .user_data_out(d2_data),
        .user_sync_out(d2_sync),
        .user_outofrange(d2_ovr),
        .user_data_valid(d2_valid),
        .aligned(d2_aligned),
        .sync_err(d2_sync_err),
        .skew_err(d2_skew),
        .ovr_count(d2_cnt)
    );

    adc_multi_demux_align #(
        .NUM_ADCS(2), .LANES(4), .SAMPLE_BITS(8), .DEMUX(4)
    ) u4 (
        .adc_clk(clk),
        .ctrl_reset(ctrl_reset),
        .adc_data_in(adc_data_in),
        .adc_sync_in(adc_sync_in),
        .adc_outofrange_in(adc_outofrange_in),
        .adc_dcm_locked(adc_dcm_locked),
        .clear_flags(clear_flags),
        .user_data_out(d4_data),
        .user_sync_out(d4_sync),
        .user_outofrange(d4_ovr),
        .user_data_valid(d4_valid),
        .aligned(d4_aligned),
        .sync_err(d4_sync_err),
        .skew_err(d4_skew),
        .ovr_count(d4_cnt)
    );

    // Sample of ADC k lane l in ramp word n
    function automatic logic [7:0] smp(input int n, input int k, input int l);
        int v;
        v = (n + 16 * l + 100 * k) % 256;
        return 8'(v);
    endfunction

    function automatic logic [63:0] word_bits(input int n);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 2; k++)
            for (int l = 0; l < 4; l++)
                w[(k*4+l)*8 +: 8] = smp(n, k, l);
        return w;
    endfunction

    // Expected packed output for consecutive words n0 .. n0+d-1
    function automatic logic [255:0] grp(input int d, input int n0);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < d; j++)
                for (int l = 0; l < 4; l++)
                    r[((k*d+j)*4+l)*8 +: 8] = smp(n0 + j, k, l);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n, input logic [1:0] s);
        adc_data_in = word_bits(n);
        adc_sync_in = s;
        @(negedge clk);
    endtask

    initial begin
        ctrl_reset        = 1'b1;
        adc_data_in       = '0;
        adc_sync_in       = '0;
        adc_outofrange_in = '0;
        adc_dcm_locked    = '0;
        clear_flags       = 1'b0;
        for (int i = 0; i < 3; i++) tick(0, 2'b00);

        chk("rst_valid", d2_valid, 0);
        chk("rst_aligned", d2_aligned, 0);
        chk("rst_data", d2_data, 0);
        chk("rst_sync", d2_sync, 0);
        chk("rst_flags", {d2_sync_err, d2_skew}, 0);
        chk("rst_cnt", d2_cnt, 0);

        ctrl_reset     = 1'b0;
        adc_dcm_locked = 2'b11;
        for (int n = 0; n < 10; n++) tick(n, 2'b00);
        chk("wait_aligned", d2_aligned, 0);
        chk("wait_valid", d2_valid, 0);

        tick(10, 2'b11);
        tick(11, 2'b11);
        chk("run_aligned", d2_aligned, 1);
        chk("run_first_novalid", d2_valid, 0);
        tick(12, 2'b11);
        chk("first_valid", d2_valid, 1);
        chk("first_data", d2_data, grp(2, 10));
        chk("first_sync", d2_sync, 4'b1111);
        tick(13, 2'b11);
        chk("mid_novalid", d2_valid, 0);
        tick(14, 2'b11);
        chk("second_valid", d2_valid, 1);
        chk("second_data", d2_data, grp(2, 12));

        tick(15, 2'b11);
        tick(16, 2'b00);
        chk("third_data", d2_data, grp(2, 14));
        chk("no_sync_err", d2_sync_err, 0);
        tick(17, 2'b11);
        tick(18, 2'b11);
        chk("realign_novalid", d2_valid, 0);
        chk("realign_err", d2_sync_err, 1);
        tick(19, 2'b11);
        chk("realign_valid", d2_valid, 1);
        chk("realign_data", d2_data, grp(2, 17));
        chk("realign_noskew", d2_skew, 0);

        tick(20, 2'b00);
        tick(21, 2'b01);
        tick(22, 2'b11);
        tick(23, 2'b11);
        chk("skew_err", d2_skew, 2'b10);
        chk("skew_data", d2_data, grp(2, 21));
        chk("skew_sync_slots", d2_sync, 4'b1011);

        clear_flags = 1'b1;
        tick(24, 2'b11);
        clear_flags = 1'b0;
        tick(25, 2'b11);
        chk("clear_skew", d2_skew, 0);
        chk("clear_sync_err", d2_sync_err, 0);
        chk("clear_data", d2_data, grp(2, 23));

        adc_dcm_locked = 2'b01;
        tick(26, 2'b11);
        tick(27, 2'b11);
        chk("unlock_aligned", d2_aligned, 0);
        chk("unlock_valid", d2_valid, 0);
        chk("unlock_hold", d2_data, grp(2, 23));

        adc_dcm_locked = 2'b11;
        tick(28, 2'b00);
        tick(29, 2'b00);
        tick(30, 2'b00);
        tick(31, 2'b11);
        tick(32, 2'b11);
        chk("relock_aligned", d2_aligned, 1);
        tick(33, 2'b11);
        chk("relock_valid", d2_valid, 1);
        chk("relock_data", d2_data, grp(2, 31));
        chk("relock_flags", {d2_sync_err, d2_skew}, 0);
        tick(34, 2'b11);
        chk("d4_mid_novalid", d4_valid, 0);
        tick(35, 2'b11);
        chk("d4_valid", d4_valid, 1);
        chk("d4_data", d4_data, grp(4, 31));
        chk("d2_after_relock", d2_data, grp(2, 33));
        tick(36, 2'b11);

        ctrl_reset = 1'b1;
        tick(37, 2'b00);
        chk("rstmid_d4_data", d4_data, 0);
        chk("rstmid_d4_valid", d4_valid, 0);
        chk("rstmid_d4_aligned", d4_aligned, 0);
        chk("rstmid_d4_sync", d4_sync, 0);
        chk("rstmid_d2_data", d2_data, 0);
        ctrl_reset = 1'b0;
        for (int n = 38; n < 43; n++) begin
            tick(n, 2'b00);
            chk("rstmid_d4_novalid", d4_valid, 0);
            chk("rstmid_d2_novalid", d2_valid, 0);
        end

        tick(43, 2'b11);
        adc_outofrange_in = 2'b01;
        for (int i = 0; i < 70000; i++) tick(44 + i, 2'b11);
        chk("ovr_aligned", d2_aligned, 1);
        chk("ovr_slots_d2", d2_ovr, 4'b0011);
        chk("ovr_slots_d4", d4_ovr, 8'h0F);
        chk("ovr_count_d2", d2_cnt, OVR_EXP);
        chk("ovr_count_d4", d4_cnt, OVR_EXP);

        adc_outofrange_in = 2'b00;
        clear_flags = 1'b1;
        tick(0, 2'b11);
        clear_flags = 1'b0;
        tick(1, 2'b11);
        chk("ovr_clear", d2_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
